// File: rtl/button_debounce_repeat_pkg.sv
// Shared board constants, repeat FSM encoding and time-to-cycles helper
// for the push-button conditioning stage.
package button_debounce_repeat_pkg;

    localparam int unsigned BOARD_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned ms);
        return freq_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/button_debounce_repeat_sync_debounce.sv
// Two-flop synchroniser, polarity normalisation and debounce filter.
// btn_level changes after DB_CYCLES consecutive samples that differ from it.
module button_debounce_repeat_sync_debounce #(
    parameter int unsigned DB_CYCLES  = 1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise,
    output logic fall
);

    localparam logic        IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [31:0] DB_LAST  = DB_CYCLES - 1;

    logic        sync_p0;
    logic        sync_p1;
    logic        s;
    logic [31:0] db_cnt;

    // stage p0/p1: metastability guard, reset to the unpressed pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= IDLE_PIN;
            sync_p1 <= IDLE_PIN;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign s = ACTIVE_LOW ? ~sync_p1 : sync_p1;

    // debounce stage: any agreeing sample restarts the qualification count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level <= 1'b0;
            db_cnt    <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                btn_level <= s;
                db_cnt    <= '0;
                rise      <= s;
                fall      <= ~s;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/button_debounce_repeat.sv
// Debounced push-button with press/release strobes and an auto-repeating
// step strobe used as the display counter's increment enable.
module button_debounce_repeat
    import button_debounce_repeat_pkg::*;
#(
    parameter int unsigned FREQ            = BOARD_FREQ,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_HZ  = 10,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse,
    output logic holding
);

    localparam int unsigned DB_CYCLES  = ms_to_cycles(FREQ, DEBOUNCE_MS);
    localparam int unsigned DLY_CYCLES = ms_to_cycles(FREQ, REPEAT_DELAY_MS);
    localparam int unsigned RPT_CYCLES = FREQ / REPEAT_RATE_HZ;
    localparam logic [31:0] DLY_LAST   = DLY_CYCLES - 1;
    localparam logic [31:0] RPT_LAST   = RPT_CYCLES - 1;

    logic        rise;
    logic        fall;
    state_t      state;
    state_t      state_nxt;
    logic [31:0] timer;
    logic [31:0] timer_nxt;
    logic        step_nxt;

    button_debounce_repeat_sync_debounce #(
        .DB_CYCLES  (DB_CYCLES),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .rise      (rise),
        .fall      (fall)
    );

    // A release always wins, so a timer expiry in the same cycle emits nothing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step_nxt  = 1'b0;
        if (fall) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        step_nxt  = 1'b1;
                        timer_nxt = '0;
                        state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (timer == DLY_LAST) begin
                        if (REPEAT_EN) begin
                            step_nxt  = 1'b1;
                            timer_nxt = '0;
                            state_nxt = REPEAT;
                        end
                    end else begin
                        timer_nxt = timer + 32'd1;
                    end
                end
                REPEAT: begin
                    if (timer == RPT_LAST) begin
                        step_nxt  = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 32'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // output stage: every strobe is a flop, so none can exceed one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            step_pulse    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            holding       <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            step_pulse    <= step_nxt;
            press_pulse   <= rise;
            release_pulse <= fall;
            holding       <= (state_nxt == REPEAT);
        end
    end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench for button_debounce_repeat with DB=4, DLY=20, RPT=10 cycles;
// one instance with auto-repeat, one without.
module tb_button_debounce_repeat;
    import button_debounce_repeat_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_a, raw_b;
    logic lvl_a, prs_a, rel_a, stp_a, hld_a;
    logic lvl_b, prs_b, rel_b, stp_b, hld_b;
    logic [4:0] out_a, out_b;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic raw;
        logic lvl;
        logic prs;
        logic rel;
        logic stp;
        logic hld;
    } vec_t;

    vec_t press_tbl[11];

    always #5 clk = ~clk;

    button_debounce_repeat #(
        .FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
        .REPEAT_RATE_HZ(100), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(lvl_a),
        .press_pulse(prs_a), .release_pulse(rel_a), .step_pulse(stp_a),
        .holding(hld_a)
    );

    button_debounce_repeat #(
        .FREQ(1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(20),
        .REPEAT_RATE_HZ(100), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(lvl_b),
        .press_pulse(prs_b), .release_pulse(rel_b), .step_pulse(stp_b),
        .holding(hld_b)
    );

    assign out_a = {lvl_a, prs_a, rel_a, stp_a, hld_a};
    assign out_b = {lvl_b, prs_b, rel_b, stp_b, hld_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %b expected %b", nm, idx, act, exp);
        end
    endtask

    // bit order {btn_level, press_pulse, release_pulse, step_pulse, holding}
    task automatic chk_out(input string tag, input int idx, input logic [4:0] got,
                           input logic [4:0] exp);
        string nm[5];
        nm[4] = "btn_level";
        nm[3] = "press_pulse";
        nm[2] = "release_pulse";
        nm[1] = "step_pulse";
        nm[0] = "holding";
        for (int b = 0; b < 5; b++) chk({tag, ".", nm[b]}, idx, got[b], exp[b]);
    endtask

    initial begin
        press_tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        press_tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        press_tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        raw_a = 1'b1;
        raw_b = 1'b1;
        tick();
        tick();
        chk_out("reset_a", 0, out_a, 5'b00000);
        chk_out("reset_b", 0, out_b, 5'b00000);
        chk("reset_state", 0, dut_a.state == IDLE, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("idle", k, out_a, 5'b00000);
        end

        // clean press: level at edge 6, press/step at edge 7
        for (int i = 0; i < 11; i++) begin
            raw_a = press_tbl[i].raw;
            tick();
            chk_out("press_tbl", i, out_a, {press_tbl[i].lvl, press_tbl[i].prs,
                    press_tbl[i].rel, press_tbl[i].stp, press_tbl[i].hld});
        end

        // hold: repeats at +20,+30,+40,+50; release lands on the +60 expiry
        for (int e = 10; e <= 72; e++) begin
            raw_a = (e <= 60) ? 1'b0 : 1'b1;
            tick();
            chk_out("hold", e, out_a, {(e < 66), 1'b0, (e == 67),
                    (e == 27 || e == 37 || e == 47 || e == 57),
                    (e >= 27 && e < 67)});
        end
        chk("hold_end_state", 0, dut_a.state == IDLE, 1'b1);

        // bounce every 2 cycles, then stable press; release hits DELAY expiry
        for (int i = 0; i < 56; i++) begin
            if (i < 20) raw_a = ((i / 2) % 2) != 0;
            else        raw_a = (i >= 40);
            tick();
            chk_out("bounce", i, out_a, {(i >= 25 && i < 45), (i == 26), (i == 46),
                    (i == 26), 1'b0});
        end

        // asynchronous reset while in DELAY, button still held
        raw_a = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("pre_rst_state", 0, dut_a.state == DELAY, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, out_a, 5'b00000);
        chk("async_rst_state", 0, dut_a.state == IDLE, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_out("requalify", k, out_a, {(k >= 6), (k == 7), 1'b0, (k == 7), 1'b0});
        end
        raw_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_out("rst_release", k, out_a, {(k < 6), 1'b0, (k == 7), 1'b0, 1'b0});
        end

        // no auto-repeat: one step only, holding stays low
        for (int k = 1; k <= 125; k++) begin
            raw_b = (k > 110);
            tick();
            chk_out("norpt", k, out_b, {(k >= 6 && k < 116), (k == 7), (k == 117),
                    (k == 7), 1'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
